// File: rtl/sensor_scan_sequencer.sv
// Round-robin scanner for the four tracker photoresistors: settle the mux, oversample
// each channel through one shared ADC, average, then publish all four readings at once.
module sensor_scan_sequencer #(
  parameter int ADC_W          = 12,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_CYCLES  = 50,
  parameter int SCAN_PERIOD    = 50000,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             err_clr,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic [1:0]       mux_sel,
  output logic [15:0]      R_vertical_1,
  output logic [15:0]      R_vertical_2,
  output logic [15:0]      R_horizontal_1,
  output logic [15:0]      R_horizontal_2,
  output logic             data_valid,
  output logic             busy,
  output logic             timeout_err
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int PER_W = $clog2(SCAN_PERIOD + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, START, CONVERT, PUBLISH, WAIT_PERIOD
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         ch_reg, ch_next;
  logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [PER_W-1:0]   period_cnt_reg, period_cnt_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic [SMP_W-1:0]   smp_cnt_reg, smp_cnt_next;
  logic [ACC_W-1:0]   acc_reg, acc_next, acc_sum;
  logic [15:0]        shadow_reg [4];
  logic [15:0]        shadow_next [4];
  logic [15:0]        r_reg [4];
  logic               data_valid_reg;
  logic               err_reg;
  logic               publish;
  logic               timeout_set;

  assign acc_sum = acc_reg + ACC_W'(adc_data);

  always_comb begin
    state_next      = state_reg;
    ch_next         = ch_reg;
    settle_cnt_next = settle_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    smp_cnt_next    = smp_cnt_reg;
    acc_next        = acc_reg;
    shadow_next     = shadow_reg;
    publish         = 1'b0;
    timeout_set     = 1'b0;
    // Period counter free-runs and saturates; only a scan start clears it.
    period_cnt_next = (&period_cnt_reg) ? period_cnt_reg : period_cnt_reg + PER_W'(1);

    case (state_reg)
      IDLE: begin
        acc_next     = '0;
        smp_cnt_next = '0;
        if (enable) begin
          ch_next         = 2'd0;
          period_cnt_next = '0;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1)) begin
          state_next = START;
        end else begin
          settle_cnt_next = settle_cnt_reg + SET_W'(1);
        end
      end
      START: begin
        tmo_cnt_next = '0;
        state_next   = enable ? CONVERT : IDLE;
      end
      CONVERT: begin
        if (adc_done) begin
          if (!enable) begin
            acc_next     = '0;
            smp_cnt_next = '0;
            state_next   = IDLE;
          end else if (smp_cnt_reg != SMP_W'(NSAMP - 1)) begin
            acc_next     = acc_sum;
            smp_cnt_next = smp_cnt_reg + SMP_W'(1);
            state_next   = START;
          end else begin
            shadow_next[ch_reg] = 16'(acc_sum >> AVG_LOG2);
            acc_next            = '0;
            smp_cnt_next        = '0;
            if (ch_reg != 2'd3) begin
              ch_next         = ch_reg + 2'd1;
              settle_cnt_next = '0;
              state_next      = SETTLE;
            end else begin
              state_next = PUBLISH;
            end
          end
        end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_set  = 1'b1;
          acc_next     = '0;
          smp_cnt_next = '0;
          state_next   = enable ? WAIT_PERIOD : IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      PUBLISH: begin
        publish = 1'b1;
        if (!enable) begin
          state_next = IDLE;
        end else if (period_cnt_reg >= PER_W'(SCAN_PERIOD - 1)) begin
          // Scan overran the period: start the next one immediately.
          ch_next         = 2'd0;
          period_cnt_next = '0;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end else begin
          state_next = WAIT_PERIOD;
        end
      end
      WAIT_PERIOD: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (period_cnt_reg >= PER_W'(SCAN_PERIOD - 1)) begin
          ch_next         = 2'd0;
          period_cnt_next = '0;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ch_reg         <= 2'd0;
      settle_cnt_reg <= '0;
      period_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      smp_cnt_reg    <= '0;
      acc_reg        <= '0;
      data_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      settle_cnt_reg <= settle_cnt_next;
      period_cnt_reg <= period_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      smp_cnt_reg    <= smp_cnt_next;
      acc_reg        <= acc_next;
      data_valid_reg <= publish;
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (timeout_set)  err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= '0;
          r_reg[gi]      <= '0;
        end else begin
          shadow_reg[gi] <= shadow_next[gi];
          if (publish) r_reg[gi] <= shadow_reg[gi];
        end
      end
    end
  endgenerate

  assign adc_start      = (state_reg == START);
  assign busy           = (state_reg == SETTLE) || (state_reg == START) ||
                          (state_reg == CONVERT) || (state_reg == PUBLISH);
  assign mux_sel        = ch_reg;
  assign data_valid     = data_valid_reg;
  assign timeout_err    = err_reg;
  assign R_vertical_1   = r_reg[0];
  assign R_vertical_2   = r_reg[1];
  assign R_horizontal_1 = r_reg[2];
  assign R_horizontal_2 = r_reg[3];

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Scoreboard bench for sensor_scan_sequencer: behavioural ADC models drive two instances,
// expected reading sets are queued per scan and compared on each data_valid.
module tb_sensor_scan_sequencer;

  localparam int SETTLE  = 5;
  localparam int PERIOD  = 200;
  localparam int TMO     = 20;
  localparam int LAT     = 3;
  // Scan length: per channel settle + 4 x (start + LAT convert cycles), plus one publish.
  localparam int SCANLEN = 4 * (SETTLE + 4 * (1 + LAT)) + 1;

  typedef struct packed {
    logic [15:0] v1, v2, h1, h2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, err_clr = 1'b0;
  logic        adc_start, adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic [1:0]  mux_sel;
  logic [15:0] R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2;
  logic        data_valid, busy, timeout_err;

  logic        adc_start2, adc_done2 = 1'b0;
  logic [11:0] adc_data2 = '0;
  logic [1:0]  mux_sel2;
  logic [15:0] r2_v1, r2_v2, r2_h1, r2_h2;
  logic        data_valid2, busy2, timeout_err2;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cnt = 0;
  int dv_times[$];
  int dv2_times[$];
  exp_t exp_q[$];

  int suppress_ch = -1;
  bit ones_mode = 0;
  bit stray_now = 0;
  int adc_cnt = 0, adc_k = 0;
  logic [1:0] last_mux = 2'd0;
  int adc_cnt2 = 0;

  sensor_scan_sequencer #(
    .ADC_W(12), .AVG_LOG2(2), .SETTLE_CYCLES(SETTLE),
    .SCAN_PERIOD(PERIOD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .mux_sel(mux_sel), .R_vertical_1(R_vertical_1), .R_vertical_2(R_vertical_2),
    .R_horizontal_1(R_horizontal_1), .R_horizontal_2(R_horizontal_2),
    .data_valid(data_valid), .busy(busy), .timeout_err(timeout_err)
  );

  sensor_scan_sequencer #(
    .ADC_W(12), .AVG_LOG2(2), .SETTLE_CYCLES(SETTLE),
    .SCAN_PERIOD(10), .TIMEOUT_CYCLES(TMO)
  ) dut_fast (
    .clk(clk), .rst(rst), .enable(1'b1), .err_clr(1'b0),
    .adc_start(adc_start2), .adc_done(adc_done2), .adc_data(adc_data2),
    .mux_sel(mux_sel2), .R_vertical_1(r2_v1), .R_vertical_2(r2_v2),
    .R_horizontal_1(r2_h1), .R_horizontal_2(r2_h2),
    .data_valid(data_valid2), .busy(busy2), .timeout_err(timeout_err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [11:0] adc_value(input logic [1:0] ch, input int k);
    if (ones_mode) return 12'hFFF;
    if (ch == 2'd0) return 12'(100 + 2 * k);
    return 12'(100 * (int'(ch) + 1));
  endfunction

  // Main ADC model: done LAT cycles after start; stray dones injected outside CONVERT.
  always @(negedge clk) begin
    adc_done = 1'b0;
    if (rst) begin
      adc_cnt  = 0;
      adc_k    = 0;
      last_mux = 2'd0;
    end else begin
      if (mux_sel != last_mux) begin
        adc_k    = 0;
        last_mux = mux_sel;
        adc_done = 1'b1;
        adc_data = 12'hABC;
      end
      if (stray_now) begin
        stray_now = 0;
        adc_done  = 1'b1;
        adc_data  = 12'hFFF;
      end
      if (adc_cnt != 0) begin
        adc_cnt--;
        if (adc_cnt == 0 && int'(mux_sel) != suppress_ch) begin
          adc_done = 1'b1;
          adc_data = adc_value(mux_sel, adc_k);
          adc_k++;
        end
      end
      if (adc_start) begin
        adc_cnt   = LAT;
        start_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    adc_done2 = 1'b0;
    if (rst) adc_cnt2 = 0;
    else begin
      if (adc_cnt2 != 0) begin
        adc_cnt2--;
        if (adc_cnt2 == 0) begin
          adc_done2 = 1'b1;
          adc_data2 = 12'd50;
        end
      end
      if (adc_start2) adc_cnt2 = LAT;
    end
  end

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      exp_t e;
      dv_cnt++;
      dv_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("dv_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("R_vertical_1", 32'(R_vertical_1), 32'(e.v1));
        check_eq("R_vertical_2", 32'(R_vertical_2), 32'(e.v2));
        check_eq("R_horizontal_1", 32'(R_horizontal_1), 32'(e.h1));
        check_eq("R_horizontal_2", 32'(R_horizontal_2), 32'(e.h2));
      end
    end
    if (!rst && data_valid2) begin
      dv2_times.push_back(cyc);
      if (dv2_times.size() <= 2) check_eq("fast_R_vertical_1", 32'(r2_v1), 32'd50);
    end
  end

  task automatic wait_dv(input int n, input string tag);
    int i = 0;
    while (dv_cnt < n && i < 3000) begin @(negedge clk); i++; end
    check_eq(tag, 32'(dv_cnt >= n), 32'd1);
  endtask

  initial begin
    exp_t e_norm, e_ones;
    int t0, i, dv_before;
    e_norm = '{v1: 16'd103, v2: 16'd200, h1: 16'd300, h2: 16'd400};
    e_ones = '{v1: 16'd4095, v2: 16'd4095, h1: 16'd4095, h2: 16'd4095};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_R_vertical_1", 32'(R_vertical_1), 32'd0);
    check_eq("rst_adc_start", 32'(adc_start), 32'd0);
    check_eq("rst_mux_sel", 32'(mux_sel), 32'd0);
    check_eq("rst_data_valid", 32'(data_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Nominal scans with stray dones in IDLE, SETTLE and WAIT_PERIOD.
    stray_now = 1;
    repeat (2) @(negedge clk);
    exp_q.push_back(e_norm);
    exp_q.push_back(e_norm);
    enable = 1'b1;
    i = 0;
    while (mux_sel != 2'd1 && i < 1000) begin @(negedge clk); i++; end
    t0 = cyc;
    i = 0;
    while (!adc_start && i < 1000) begin @(negedge clk); i++; end
    check_eq("settle_gap", 32'(cyc - t0), 32'(SETTLE));
    wait_dv(1, "dv_first");
    stray_now = 1;
    wait_dv(2, "dv_second");
    if (dv_times.size() >= 2)
      check_eq("dv_spacing", 32'(dv_times[1] - dv_times[0]), 32'(PERIOD));

    // Timeout on ch2.
    suppress_ch = 2;
    dv_before = dv_cnt;
    i = 0;
    while (!timeout_err && i < 3000) begin @(negedge clk); i++; end
    check_eq("tmo_flag", 32'(timeout_err), 32'd1);
    check_eq("tmo_latency", 32'(cyc - start_cyc), 32'(TMO + 1));
    repeat (10) @(negedge clk);
    check_eq("tmo_no_dv", 32'(dv_cnt), 32'(dv_before));
    check_eq("tmo_R_hold", 32'(R_horizontal_1), 32'd300);
    suppress_ch = -1;
    exp_q.push_back(e_norm);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("err_clr", 32'(timeout_err), 32'd0);
    wait_dv(dv_before + 1, "dv_after_clr");

    // Drop enable during SETTLE of ch1.
    i = 0;
    while (mux_sel != 2'd1 && i < 1000) begin @(negedge clk); i++; end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    dv_before = dv_cnt;
    @(negedge clk);
    check_eq("abort_idle", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("abort_no_dv", 32'(dv_cnt), 32'(dv_before));
    check_eq("abort_R_hold", 32'(R_vertical_1), 32'd103);

    // Re-enable with full-scale data.
    ones_mode = 1;
    exp_q.push_back(e_ones);
    enable = 1'b1;
    @(negedge clk);
    check_eq("restart_ch0", 32'(mux_sel), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'd1);
    wait_dv(dv_before + 1, "dv_ones");

    // Timeout on ch0, then reset mid-CONVERT of the next scan.
    suppress_ch = 0;
    i = 0;
    while (!timeout_err && i < 3000) begin @(negedge clk); i++; end
    check_eq("tmo2_flag", 32'(timeout_err), 32'd1);
    i = 0;
    while (!adc_start && i < 1000) begin @(negedge clk); i++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst2_R_vertical_1", 32'(R_vertical_1), 32'd0);
    check_eq("rst2_R_horizontal_2", 32'(R_horizontal_2), 32'd0);
    check_eq("rst2_busy", 32'(busy), 32'd0);
    check_eq("rst2_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst2_data_valid", 32'(data_valid), 32'd0);
    check_eq("rst2_adc_start", 32'(adc_start), 32'd0);
    rst = 1'b0;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    check_eq("fast_dv_count", 32'(dv2_times.size() >= 3), 32'd1);
    if (dv2_times.size() >= 3)
      check_eq("fast_back_to_back", 32'(dv2_times[2] - dv2_times[1]), 32'(SCANLEN));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
